rand_par_stream: RTL and testbench



---
 rtl/rand_pkg.sv | 37 +++
 rtl/rand_par_stream_if.sv | 12 +
 rtl/rand_lfsr_unroll.sv | 25 ++
 rtl/rand_par_stream.sv | 136 +++++++++++++
 tb/tb_rand_par_stream.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rand_pkg.sv
// Shared definitions for the PRBS 1+x^14+x^15 randomizer family (TX scrambler, RX derandomizer).
package rand_pkg;

    localparam int unsigned RAND_LEN   = 15;
    localparam int unsigned RAND_TAP_A = 14;
    localparam int unsigned RAND_TAP_B = 13;

    typedef enum logic {
        IDLE,
        RUN
    } rand_state_t;

    typedef struct packed {
        logic [RAND_LEN-1:0] vect;
        logic [RAND_LEN-1:0] bits;
    } rand_step_t;

    // Advance the LFSR n times (n <= RAND_LEN). bits[n-1] is the earliest bit in time,
    // and each bit is XORed with the feedback produced by its own step.
    function automatic rand_step_t rand_step(input logic [RAND_LEN-1:0] vect,
                                             input logic [RAND_LEN-1:0] bits,
                                             input int unsigned         n);
        rand_step_t r;
        logic       fb;
        r.vect = vect;
        r.bits = bits;
        for (int unsigned i = 0; i < RAND_LEN; i++) begin
            if (i < n) begin
                fb               = r.vect[RAND_TAP_A] ^ r.vect[RAND_TAP_B];
                r.bits[n - 1 - i] = bits[n - 1 - i] ^ fb;
                r.vect           = {r.vect[RAND_LEN-2:0], fb};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rand_par_stream_if.sv
// Valid/ready stream carrying W data bits plus a burst-end marker.
interface rand_par_stream_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         last;
    logic         ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/rand_lfsr_unroll.sv
// Combinational W-step LFSR advance and keystream XOR; shared with the RX derandomizer.
module rand_lfsr_unroll
    import rand_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [RAND_LEN-1:0] vect_i,
    input  logic [W-1:0]        data_i,
    output logic [RAND_LEN-1:0] vect_o,
    output logic [W-1:0]        data_o
);

    rand_step_t step;
    logic       unused_bits;

    // Unroll all W steps for one beat
    always_comb begin
        step = rand_step(vect_i, RAND_LEN'(data_i), W);
    end

    assign vect_o      = step.vect;
    assign data_o      = step.bits[W-1:0];
    assign unused_bits = ^step.bits;

endmodule

// File: rtl/rand_par_stream.sv
// W-bit-per-clock PRBS burst scrambler with valid/ready on both sides and per-burst IV reload.
// Optional build macro RAND_BITCNT_EN adds the bit_cnt output (scrambled bits in current burst).
module rand_par_stream
    import rand_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RAND_LEN-1:0] rand_iv,
    input  logic                iv_load,
    rand_par_stream_if.slave    in_bus,
    rand_par_stream_if.master   out_bus,
    output logic                load_err,
    output logic                busy
`ifdef RAND_BITCNT_EN
    ,
    output logic [CW-1:0]       bit_cnt
`endif
);

    rand_state_t         state_q, state_d;
    logic [RAND_LEN-1:0] vect_q, vect_d;
    logic [W-1:0]        out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                load_err_q, load_err_d;

    logic [RAND_LEN-1:0] scr_vect;
    logic [W-1:0]        scr_data;
    logic                in_ready;
    logic                accept;

    rand_lfsr_unroll #(.W(W)) u_unroll (
        .vect_i (vect_q),
        .data_i (in_bus.data),
        .vect_o (scr_vect),
        .data_o (scr_data)
    );

    assign in_ready = (state_q == RUN) && (!out_valid_q || out_bus.ready);
    assign accept   = in_bus.valid && in_ready;

    // Next-state: IV load, LFSR advance on accepted beats, output register fill/drain
    always_comb begin
        state_d     = state_q;
        vect_d      = vect_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        load_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iv_load) begin
                    vect_d  = rand_iv;
                    state_d = RUN;
                end
            end
            RUN: begin
                // a load coinciding with the final beat is still a load during RUN
                if (iv_load) begin
                    load_err_d = 1'b1;
                end
                if (accept) begin
                    vect_d = scr_vect;
                    if (in_bus.last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            out_data_d  = scr_data;
            out_valid_d = 1'b1;
            out_last_d  = in_bus.last;
        end else if (out_bus.ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output register flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vect_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vect_q      <= vect_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            load_err_q  <= load_err_d;
        end
    end

`ifdef RAND_BITCNT_EN
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;

    // Burst bit counter: cleared on a taken load, +W per accepted beat, held in IDLE
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (state_q == IDLE && iv_load) begin
            bit_cnt_d = '0;
        end else if (accept) begin
            bit_cnt_d = bit_cnt_q + CW'(W);
        end
    end

    // Bit counter flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_cnt = bit_cnt_q;
`else
    localparam int unsigned unused_cw = CW;
`endif

    assign in_bus.ready  = in_ready;
    assign out_bus.data  = out_data_q;
    assign out_bus.valid = out_valid_q;
    assign out_bus.last  = out_last_q;
    assign load_err      = load_err_q;
    assign busy          = (state_q == RUN) || out_valid_q;

endmodule

// File: tb/tb_rand_par_stream.sv
// Directed self-checking bench for rand_par_stream (W=8 and W=1 instances).
module tb_rand_par_stream;
    import rand_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] rand_iv;
    logic        iv_load;
    logic        iv_load1;
    logic        load_err8, busy8, load_err1, busy1;
    int          checks   = 0;
    int          failures = 0;

    logic [7:0]  src [32];
    logic [7:0]  enc [32];
    logic [7:0]  expb[40];
    logic [14:0] mv;

    always #5 clk = ~clk;

    rand_par_stream_if #(.W(8)) in8 ();
    rand_par_stream_if #(.W(8)) out8 ();
    rand_par_stream_if #(.W(1)) in1 ();
    rand_par_stream_if #(.W(1)) out1 ();

`ifdef RAND_BITCNT_EN
    logic [7:0]  bc8;
    logic [15:0] bc1;
`endif

    rand_par_stream #(.W(8), .CW(8)) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .rand_iv  (rand_iv),
        .iv_load  (iv_load),
        .in_bus   (in8),
        .out_bus  (out8),
        .load_err (load_err8),
        .busy     (busy8)
`ifdef RAND_BITCNT_EN
        ,
        .bit_cnt  (bc8)
`endif
    );

    rand_par_stream #(.W(1), .CW(16)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .rand_iv  (rand_iv),
        .iv_load  (iv_load1),
        .in_bus   (in1),
        .out_bus  (out1),
        .load_err (load_err1),
        .busy     (busy1)
`ifdef RAND_BITCNT_EN
        ,
        .bit_cnt  (bc1)
`endif
    );

    // Bit-serial reference scrambler; state in mv
    function automatic logic [7:0] model_byte(input logic [7:0] d);
        logic [7:0] o;
        logic       fb;
        for (int k = 7; k >= 0; k--) begin
            fb   = mv[14] ^ mv[13];
            o[k] = d[k] ^ fb;
            mv   = {mv[13:0], fb};
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [14:0] iv);
        rand_iv = iv;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
    endtask

    task automatic load1(input logic [14:0] iv);
        rand_iv  = iv;
        iv_load1 = 1'b1;
        tick();
        iv_load1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (out8.valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out8.valid); end
        checks++; if (out8.data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out8.data); end
        checks++; if (out8.last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0h exp=0", out8.last); end
        checks++; if (load_err8 !== 1'b0) begin failures++; $display("FAIL reset_load_err got=%0h exp=0", load_err8); end
        checks++; if (in8.ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0h exp=0", in8.ready); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy8); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        load8(15'h3715);
        in8.valid = 1'b1; in8.data = 8'h00; in8.last = 1'b1;
        tick();
        in8.valid = 1'b0; in8.last = 1'b0;
        checks++; if (out8.valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", out8.valid); end
        checks++; if (out8.data !== 8'hB2) begin failures++; $display("FAIL single_data got=%0h exp=b2", out8.data); end
        checks++; if (out8.last !== 1'b1) begin failures++; $display("FAIL single_last got=%0h exp=1", out8.last); end
        checks++; if (in8.ready !== 1'b0) begin failures++; $display("FAIL single_idle_ready got=%0h exp=0", in8.ready); end
        checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL single_busy_drain got=%0h exp=1", busy8); end
        tick();
        checks++; if (out8.valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%0h exp=0", out8.valid); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%0h exp=0", busy8); end
    endtask

    task automatic test_zero_iv();
        load8(15'h0000);
        in8.valid = 1'b1; in8.data = 8'hA5; in8.last = 1'b1;
        tick();
        in8.valid = 1'b0; in8.last = 1'b0;
        checks++; if (out8.data !== 8'hA5) begin failures++; $display("FAIL zero_iv_data got=%0h exp=a5", out8.data); end
        tick();
    endtask

    task automatic test_stream();
        logic [7:0] e;
        for (int i = 0; i < 32; i++) src[i] = 8'($urandom_range(0, 255));
        mv = 15'h3715;
        load8(15'h3715);
        for (int i = 0; i < 32; i++) begin
            in8.valid = 1'b1; in8.data = src[i]; in8.last = (i == 31);
            tick();
            e = model_byte(src[i]);
            enc[i] = out8.data;
            checks++;
            if (out8.valid !== 1'b1 || out8.data !== e) begin
                failures++; $display("FAIL stream8_beat%0d got=%0h/v%0h exp=%0h/v1", i, out8.data, out8.valid, e);
            end
        end
        in8.valid = 1'b0; in8.last = 1'b0;
        tick();
        // W=1 instance must produce the same serial bitstream
        load1(15'h3715);
        for (int i = 0; i < 32; i++) begin
            logic [7:0] b, got;
            logic       vok;
            b = src[i]; got = '0; vok = 1'b1;
            for (int k = 7; k >= 0; k--) begin
                in1.valid = 1'b1; in1.data = b[k]; in1.last = (i == 31 && k == 0);
                tick();
                got[k] = out1.data[0];
                if (out1.valid !== 1'b1) vok = 1'b0;
            end
            checks++;
            if (got !== enc[i] || !vok) begin
                failures++; $display("FAIL stream1_byte%0d got=%0h valid_ok=%0d exp=%0h", i, got, vok, enc[i]);
            end
        end
        in1.valid = 1'b0; in1.last = 1'b0;
        tick();
        // Scrambling the scrambled stream again with the same IV restores the source
        load8(15'h3715);
        for (int i = 0; i < 32; i++) begin
            in8.valid = 1'b1; in8.data = enc[i]; in8.last = (i == 31);
            tick();
            checks++;
            if (out8.data !== src[i]) begin
                failures++; $display("FAIL descramble_beat%0d got=%0h exp=%0h", i, out8.data, src[i]);
            end
        end
        in8.valid = 1'b0; in8.last = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int         si, ki;
        logic       acc, xfer;
        logic [7:0] od;
        logic       ol;
        mv = 15'h1234;
        for (int i = 0; i < 10; i++) begin
            src[i]  = 8'(8'h11 * i + 8'h03);
            expb[i] = model_byte(src[i]);
        end
        load8(15'h1234);
        si = 0; ki = 0;
        for (int cyc = 0; cyc < 40 && ki < 10; cyc++) begin
            in8.valid  = (si < 10);
            in8.data   = (si < 10) ? src[si] : 8'h00;
            in8.last   = (si == 9);
            out8.ready = !(cyc >= 3 && cyc < 8);
            #1;
            acc  = in8.valid && in8.ready;
            xfer = out8.valid && out8.ready;
            od   = out8.data;
            ol   = out8.last;
            if (out8.valid && !out8.ready) begin
                checks++; if (in8.ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready cyc%0d got=%0h exp=0", cyc, in8.ready); end
                checks++; if (od !== expb[ki]) begin failures++; $display("FAIL bp_stall_data cyc%0d got=%0h exp=%0h", cyc, od, expb[ki]); end
            end
            if (out8.ready && si < 10) begin
                checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bp_throughput cyc%0d accepted=%0h exp=1", cyc, acc); end
            end
            if (xfer) begin
                checks++; if (od !== expb[ki] || ol !== (ki == 9)) begin
                    failures++; $display("FAIL bp_out%0d got=%0h/l%0h exp=%0h/l%0h", ki, od, ol, expb[ki], (ki == 9));
                end
                ki++;
            end
            if (acc) si++;
            tick();
        end
        in8.valid = 1'b0; in8.last = 1'b0; out8.ready = 1'b1;
        checks++; if (ki != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", ki); end
        tick();
    endtask

    task automatic test_load_err();
        mv = 15'h1234;
        for (int i = 0; i < 6; i++) expb[i] = model_byte(src[i]);
        load8(15'h1234);
        for (int i = 0; i < 6; i++) begin
            in8.valid = 1'b1; in8.data = src[i]; in8.last = (i == 5);
            if (i == 2) begin rand_iv = 15'h7FFF; iv_load = 1'b1; end
            tick();
            iv_load = 1'b0;
            checks++; if (out8.data !== expb[i]) begin failures++; $display("FAIL lerr_beat%0d got=%0h exp=%0h", i, out8.data, expb[i]); end
            if (i == 2) begin
                checks++; if (load_err8 !== 1'b1) begin failures++; $display("FAIL lerr_pulse got=%0h exp=1", load_err8); end
            end
            if (i == 3) begin
                checks++; if (load_err8 !== 1'b0) begin failures++; $display("FAIL lerr_one_cycle got=%0h exp=0", load_err8); end
            end
        end
        in8.valid = 1'b0; in8.last = 1'b0;
        tick();
        // load coinciding with the final beat is rejected
        load8(15'h3715);
        in8.valid = 1'b1; in8.data = 8'h00; in8.last = 1'b1;
        rand_iv = 15'h7FFF; iv_load = 1'b1;
        tick();
        iv_load = 1'b0; in8.valid = 1'b0; in8.last = 1'b0;
        checks++; if (load_err8 !== 1'b1) begin failures++; $display("FAIL lastload_err got=%0h exp=1", load_err8); end
        checks++; if (out8.data !== 8'hB2) begin failures++; $display("FAIL lastload_data got=%0h exp=b2", out8.data); end
        tick();
        checks++; if (in8.ready !== 1'b0) begin failures++; $display("FAIL lastload_idle got=%0h exp=0", in8.ready); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL lastload_busy got=%0h exp=0", busy8); end
    endtask

    task automatic test_reset_mid();
        load8(15'h3715);
        for (int i = 0; i < 3; i++) begin
            in8.valid = 1'b1; in8.data = src[i]; in8.last = 1'b0;
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out8.valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0h exp=0", out8.valid); end
        checks++; if (out8.data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%0h exp=0", out8.data); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0h exp=0", busy8); end
        tick();
        reset = 1'b0;
        in8.valid = 1'b1; in8.data = 8'h00; in8.last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (in8.ready !== 1'b0) begin failures++; $display("FAIL rstmid_noload_ready%0d got=%0h exp=0", i, in8.ready); end
        end
        in8.valid = 1'b0;
        load8(15'h3715);
        in8.valid = 1'b1;
        tick();
        in8.valid = 1'b0; in8.last = 1'b0;
        checks++; if (out8.data !== 8'hB2) begin failures++; $display("FAIL rstmid_reload got=%0h exp=b2", out8.data); end
        tick();
    endtask

`ifdef RAND_BITCNT_EN
    task automatic test_bitcnt();
        load8(15'h0001);
        checks++; if (bc8 !== 8'd0) begin failures++; $display("FAIL bitcnt_clear got=%0d exp=0", bc8); end
        for (int i = 0; i < 40; i++) begin
            in8.valid = 1'b1; in8.data = 8'(i); in8.last = (i == 39);
            tick();
        end
        in8.valid = 1'b0; in8.last = 1'b0;
        checks++; if (bc8 !== 8'd64) begin failures++; $display("FAIL bitcnt_wrap got=%0d exp=64", bc8); end
        tick();
        checks++; if (bc8 !== 8'd64) begin failures++; $display("FAIL bitcnt_hold got=%0d exp=64", bc8); end
        load8(15'h3715);
        checks++; if (bc8 !== 8'd0) begin failures++; $display("FAIL bitcnt_reload got=%0d exp=0", bc8); end
        in8.valid = 1'b1; in8.data = 8'h00; in8.last = 1'b1;
        tick();
        in8.valid = 1'b0; in8.last = 1'b0;
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1; rand_iv = '0; iv_load = 1'b0; iv_load1 = 1'b0;
        in8.valid = 1'b0; in8.data = '0; in8.last = 1'b0; out8.ready = 1'b1;
        in1.valid = 1'b0; in1.data = '0; in1.last = 1'b0; out1.ready = 1'b1;
        test_reset();
        test_single();
        test_zero_iv();
        test_stream();
        test_backpressure();
        test_load_err();
        test_reset_mid();
`ifdef RAND_BITCNT_EN
        test_bitcnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
